// File: rtl/multiplier_datapath_if.sv
// Command/operand/result bundle between the multiplier control FSM and the datapath.
// The slave modport belongs to the datapath; the master modport belongs to the FSM or bench.
interface multiplier_datapath_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0]         S;
    logic                     clra_ldb;
    logic                     clr_xa;
    logic                     shift;
    logic                     add;
    logic                     sub;
    logic [WIDTH-1:0]         A;
    logic [WIDTH-1:0]         B;
    logic                     X;
    logic [1:0]               M_signal;
    logic [$clog2(WIDTH):0]   shift_count;
    logic                     done;
    logic                     cmd_err;

    modport slave (
        input  S, clra_ldb, clr_xa, shift, add, sub,
        output A, B, X, M_signal, shift_count, done, cmd_err
    );

    modport master (
        output S, clra_ldb, clr_xa, shift, add, sub,
        input  A, B, X, M_signal, shift_count, done, cmd_err
    );
endinterface

// File: rtl/multiplier_datapath.sv
// Signed shift-add multiplier datapath: X/A/B registers, WIDTH+1-bit add/sub against S,
// shift counter with saturation, and a sticky flag for conflicting commands.
module multiplier_datapath #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    multiplier_datapath_if.slave   bus
);
    localparam int unsigned CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

    typedef enum logic [2:0] {
        CMD_NONE,
        CMD_LOAD,
        CMD_CLEAR,
        CMD_SUB,
        CMD_ADD,
        CMD_SHIFT
    } cmd_e;

    logic             x_q, x_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             err_q, err_d;

    cmd_e             cmd;
    logic [2:0]       n_cmds;
    logic             sub_sel;
    logic [WIDTH:0]   a_ext;
    logic [WIDTH:0]   s_ext;
    logic [WIDTH:0]   s_opnd;
    logic [WIDTH:0]   sum;

    always_comb begin
        cmd = CMD_NONE;
        if (bus.clra_ldb)    cmd = CMD_LOAD;
        else if (bus.clr_xa) cmd = CMD_CLEAR;
        else if (bus.sub)    cmd = CMD_SUB;
        else if (bus.add)    cmd = CMD_ADD;
        else if (bus.shift)  cmd = CMD_SHIFT;
    end

    always_comb begin
        n_cmds = {2'b00, bus.clra_ldb} + {2'b00, bus.clr_xa} + {2'b00, bus.shift}
               + {2'b00, bus.add} + {2'b00, bus.sub};
    end

    // Subtraction reuses the adder: invert the sign-extended operand and inject carry-in.
    always_comb begin
        sub_sel = (cmd == CMD_SUB);
        a_ext   = {a_q[WIDTH-1], a_q};
        s_ext   = {bus.S[WIDTH-1], bus.S};
        s_opnd  = sub_sel ? ~s_ext : s_ext;
        sum     = a_ext + s_opnd + {{WIDTH{1'b0}}, sub_sel};
    end

    always_comb begin
        x_d   = x_q;
        a_d   = a_q;
        b_d   = b_q;
        cnt_d = cnt_q;
        err_d = err_q | (n_cmds > 3'd1);
        unique case (cmd)
            CMD_LOAD: begin
                x_d   = 1'b0;
                a_d   = '0;
                b_d   = bus.S;
                cnt_d = '0;
            end
            CMD_CLEAR: begin
                x_d   = 1'b0;
                a_d   = '0;
                cnt_d = '0;
            end
            CMD_SUB, CMD_ADD: begin
                x_d = sum[WIDTH];
                a_d = sum[WIDTH-1:0];
            end
            CMD_SHIFT: begin
                a_d = {x_q, a_q[WIDTH-1:1]};
                b_d = {a_q[0], b_q[WIDTH-1:1]};
                if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_q   <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            x_q   <= x_d;
            a_q   <= a_d;
            b_q   <= b_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    // M_signal taps the register directly so the FSM sees pre-shift B[1] during a shift cycle.
    assign bus.A           = a_q;
    assign bus.B           = b_q;
    assign bus.X           = x_q;
    assign bus.M_signal    = b_q[1:0];
    assign bus.shift_count = cnt_q;
    assign bus.done        = (cnt_q == CNT_MAX);
    assign bus.cmd_err     = err_q;
endmodule

// File: tb/tb_multiplier_datapath.sv
// Directed bench for multiplier_datapath: hand-computed X/A/B/count/flag values per scenario.
module tb_multiplier_datapath;
    localparam logic [4:0] C_LDB = 5'b10000;
    localparam logic [4:0] C_CLR = 5'b01000;
    localparam logic [4:0] C_SHF = 5'b00100;
    localparam logic [4:0] C_ADD = 5'b00010;
    localparam logic [4:0] C_SUB = 5'b00001;

    logic clk;
    logic reset;
    int   n_pass;
    int   n_total;

    multiplier_datapath_if #(.WIDTH(8)) bus ();

    multiplier_datapath #(.WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic [4:0] c, input logic [7:0] s);
        @(negedge clk);
        {bus.clra_ldb, bus.clr_xa, bus.shift, bus.add, bus.sub} = c;
        bus.S = s;
        @(posedge clk);
        #1;
        {bus.clra_ldb, bus.clr_xa, bus.shift, bus.add, bus.sub} = 5'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.S = 8'($urandom);
        {bus.clra_ldb, bus.clr_xa, bus.shift, bus.add, bus.sub} = 5'($urandom);
        #1;
        n_total++;
        if ({bus.X, bus.A, bus.B, bus.shift_count, bus.done, bus.cmd_err, bus.M_signal} !== 24'h0)
            $display("FAIL reset_state: got X=%b A=%h B=%h cnt=%0d done=%b err=%b M=%b, want all 0",
                     bus.X, bus.A, bus.B, bus.shift_count, bus.done, bus.cmd_err, bus.M_signal);
        else n_pass++;
        @(negedge clk);
        {bus.clra_ldb, bus.clr_xa, bus.shift, bus.add, bus.sub} = 5'b0;
        reset = 1'b1;
        drive(C_LDB, 8'h07);
        n_total++;
        if ({bus.X, bus.A, bus.B} !== {1'b0, 8'h00, 8'h07})
            $display("FAIL load_b: got X=%b A=%h B=%h, want X=0 A=00 B=07", bus.X, bus.A, bus.B);
        else n_pass++;
        n_total++;
        if (bus.M_signal !== 2'b11)
            $display("FAIL m_signal_load: got %b, want 11", bus.M_signal);
        else n_pass++;
    endtask

    // 7 x (-3): B=07 has bits 0-2 set, bit 7 clear, so no final subtract.
    task automatic test_mult_pos_neg();
        drive(C_LDB, 8'h07);
        drive(C_CLR, 8'hFD);
        for (int i = 0; i < 8; i++) begin
            if (i < 3) drive(C_ADD, 8'hFD);
            drive(C_SHF, 8'hFD);
        end
        n_total++;
        if ({bus.X, bus.A, bus.B} !== {1'b1, 8'hFF, 8'hEB})
            $display("FAIL mult_7x_m3: got X=%b A=%h B=%h, want X=1 A=FF B=EB", bus.X, bus.A, bus.B);
        else n_pass++;
        n_total++;
        if (bus.done !== 1'b1 || bus.shift_count !== 4'd8)
            $display("FAIL mult_7x_m3_done: got done=%b cnt=%0d, want done=1 cnt=8", bus.done, bus.shift_count);
        else n_pass++;
    endtask

    task automatic test_mult_min_min();
        drive(C_LDB, 8'h80);
        for (int i = 0; i < 7; i++) drive(C_SHF, 8'h80);
        n_total++;
        if (bus.done !== 1'b0 || bus.shift_count !== 4'd7 || bus.B !== 8'h01)
            $display("FAIL min_seven_shifts: got done=%b cnt=%0d B=%h, want done=0 cnt=7 B=01",
                     bus.done, bus.shift_count, bus.B);
        else n_pass++;
        drive(C_SUB, 8'h80);
        n_total++;
        if ({bus.X, bus.A} !== {1'b0, 8'h80})
            $display("FAIL min_after_sub: got X=%b A=%h, want X=0 A=80", bus.X, bus.A);
        else n_pass++;
        drive(C_SHF, 8'h80);
        n_total++;
        if ({bus.X, bus.A, bus.B} !== {1'b0, 16'h4000})
            $display("FAIL min_product: got X=%b AB=%h, want X=0 AB=4000", bus.X, {bus.A, bus.B});
        else n_pass++;
    endtask

    task automatic test_adder_boundary();
        drive(C_LDB, 8'h00);
        drive(C_ADD, 8'h7F);
        drive(C_ADD, 8'h01);
        n_total++;
        if ({bus.X, bus.A} !== {1'b0, 8'h80})
            $display("FAIL add_7f_plus_1: got X=%b A=%h, want X=0 A=80", bus.X, bus.A);
        else n_pass++;
        // A=80 sign-extends to -128, so -128-1 = -129 = 9'h17F.
        drive(C_SUB, 8'h01);
        n_total++;
        if ({bus.X, bus.A} !== {1'b1, 8'h7F})
            $display("FAIL sub_80_minus_1: got X=%b A=%h, want X=1 A=7F", bus.X, bus.A);
        else n_pass++;
    endtask

    task automatic test_priority_error();
        drive(C_CLR, 8'h05);
        n_total++;
        if (bus.cmd_err !== 1'b0 || bus.A !== 8'h00)
            $display("FAIL err_clear_before: got err=%b A=%h, want err=0 A=00", bus.cmd_err, bus.A);
        else n_pass++;
        drive(C_ADD | C_SUB, 8'h05);
        n_total++;
        if ({bus.X, bus.A} !== {1'b1, 8'hFB})
            $display("FAIL sub_wins: got X=%b A=%h, want X=1 A=FB", bus.X, bus.A);
        else n_pass++;
        n_total++;
        if (bus.cmd_err !== 1'b1)
            $display("FAIL cmd_err_set: got %b, want 1", bus.cmd_err);
        else n_pass++;
        drive(C_LDB | C_SHF, 8'h3C);
        n_total++;
        if ({bus.X, bus.A, bus.B, bus.shift_count} !== {1'b0, 8'h00, 8'h3C, 4'd0})
            $display("FAIL ldb_wins: got X=%b A=%h B=%h cnt=%0d, want X=0 A=00 B=3C cnt=0",
                     bus.X, bus.A, bus.B, bus.shift_count);
        else n_pass++;
    endtask

    task automatic test_saturation_abort();
        drive(C_LDB, 8'hA5);
        drive(C_ADD, 8'h7F);
        for (int i = 0; i < 10; i++) begin
            drive(C_SHF, 8'h00);
            if (i == 7) begin
                n_total++;
                if (bus.shift_count !== 4'd8 || bus.done !== 1'b1)
                    $display("FAIL sat_at_8: got cnt=%0d done=%b, want cnt=8 done=1", bus.shift_count, bus.done);
                else n_pass++;
            end
        end
        n_total++;
        if (bus.shift_count !== 4'd8 || bus.done !== 1'b1)
            $display("FAIL sat_after_10: got cnt=%0d done=%b, want cnt=8 done=1", bus.shift_count, bus.done);
        else n_pass++;
        n_total++;
        if ({bus.X, bus.A, bus.B} !== {1'b0, 8'h00, 8'h1F})
            $display("FAIL sat_data: got X=%b A=%h B=%h, want X=0 A=00 B=1F", bus.X, bus.A, bus.B);
        else n_pass++;
        drive(C_ADD, 8'hC3);
        drive(C_CLR, 8'h00);
        n_total++;
        if ({bus.X, bus.A, bus.B, bus.shift_count, bus.done} !== {1'b0, 8'h00, 8'h1F, 4'd0, 1'b0})
            $display("FAIL abort_clr: got X=%b A=%h B=%h cnt=%0d done=%b, want X=0 A=00 B=1F cnt=0 done=0",
                     bus.X, bus.A, bus.B, bus.shift_count, bus.done);
        else n_pass++;
        n_total++;
        if (bus.cmd_err !== 1'b1 || bus.M_signal !== 2'b11)
            $display("FAIL err_sticky: got err=%b M=%b, want err=1 M=11", bus.cmd_err, bus.M_signal);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        drive(C_ADD, 8'h55);
        drive(C_SHF, 8'h00);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        n_total++;
        if ({bus.X, bus.A, bus.B, bus.shift_count, bus.cmd_err} !== 22'h0)
            $display("FAIL async_reset: got X=%b A=%h B=%h cnt=%0d err=%b, want all 0",
                     bus.X, bus.A, bus.B, bus.shift_count, bus.cmd_err);
        else n_pass++;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        bus.S = '0;
        {bus.clra_ldb, bus.clr_xa, bus.shift, bus.add, bus.sub} = 5'b0;
        test_reset();
        test_mult_pos_neg();
        test_mult_min_min();
        test_adder_boundary();
        test_priority_error();
        test_saturation_abort();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
